// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-pin bundle shared by mem_port_arbiter and its environment.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_addr, mem_wr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter and sequencer for a single-port 64-bit memory.
// Optional MEM_ARB_RMW_EN: sub-word stores are done internally as read-modify-write.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned INSN_W = 32;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_RWAIT    = 3'd2;
    localparam logic [2:0] S_WR       = 3'd3;
    localparam logic [2:0] S_ERR      = 3'd4;
`ifdef MEM_ARB_RMW_EN
    localparam logic [2:0] S_RMW_RD   = 3'd5;
    localparam logic [2:0] S_RMW_WAIT = 3'd6;
    localparam logic [2:0] S_RMW_WR   = 3'd7;
`endif

    logic [2:0]        state_q, state_d;
    logic              last_was_data_q, last_was_data_d;
    logic              d_mis_c;

    logic              is_data_q;
    logic              hi_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_wr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_rvalid_q;
    logic [INSN_W-1:0] if_rdata_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              d_err_q;

    // Fetch addresses are 4-aligned; their two LSBs carry no information.
    logic              unused_if_lsb;
    assign unused_if_lsb = ^bus.if_addr[1:0];

    // Misalignment of the currently offered data request.
    always_comb begin
        d_mis_c = 1'b0;
        case (bus.d_size)
            2'd1:    d_mis_c = bus.d_addr[0];
            2'd2:    d_mis_c = |bus.d_addr[1:0];
            2'd3:    d_mis_c = |bus.d_addr[2:0];
            default: d_mis_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            last_was_data_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_was_data_q <= last_was_data_d;
        end
    end

    // Next state and combinational grants; data wins unless it won last time and fetch waits.
    always_comb begin
        state_d         = state_q;
        last_was_data_d = last_was_data_q;
        bus.if_gnt      = 1'b0;
        bus.d_gnt       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.d_req && !(last_was_data_q && bus.if_req)) begin
                    bus.d_gnt       = 1'b1;
                    last_was_data_d = 1'b1;
                    if (d_mis_c)
                        state_d = S_ERR;
                    else if (!bus.d_we)
                        state_d = S_RD;
`ifdef MEM_ARB_RMW_EN
                    else if (bus.d_size != 2'd3)
                        state_d = S_RMW_RD;
`endif
                    else
                        state_d = S_WR;
                end else if (bus.if_req) begin
                    bus.if_gnt      = 1'b1;
                    last_was_data_d = 1'b0;
                    state_d         = S_RD;
                end
            end
            S_RD:       state_d = S_RWAIT;
            S_RWAIT:    state_d = S_IDLE;
            S_WR:       state_d = S_IDLE;
            S_ERR:      state_d = S_IDLE;
`ifdef MEM_ARB_RMW_EN
            S_RMW_RD:   state_d = S_RMW_WAIT;
            S_RMW_WAIT: state_d = S_RMW_WR;
            S_RMW_WR:   state_d = S_IDLE;
`endif
            default:    state_d = S_IDLE;
        endcase
    end

`ifdef MEM_ARB_RMW_EN
    logic [2:0]        off_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mask_c;
    logic [DATA_W-1:0] merged_c;
    logic [5:0]        shamt_c;

    // Place the right-aligned store lanes over the freshly read dword.
    always_comb begin
        case (size_q)
            2'd0:    mask_c = DATA_W'(64'h0000_0000_0000_00FF);
            2'd1:    mask_c = DATA_W'(64'h0000_0000_0000_FFFF);
            default: mask_c = DATA_W'(64'h0000_0000_FFFF_FFFF);
        endcase
        shamt_c  = {off_q, 3'b000};
        merged_c = (bus.mem_rdata & ~(mask_c << shamt_c)) | ((wdata_q & mask_c) << shamt_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_q   <= 3'd0;
            size_q  <= 2'd0;
            wdata_q <= '0;
        end else if (bus.d_gnt) begin
            off_q   <= bus.d_addr[2:0];
            size_q  <= bus.d_size;
            wdata_q <= bus.d_wdata;
        end
    end
`endif

    // Registered memory pins, read data and response pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_data_q   <= 1'b0;
            hi_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
`ifdef MEM_ARB_RMW_EN
            mem_wr_q    <= (state_d == S_WR) || (state_d == S_RMW_WR);
`else
            mem_wr_q    <= (state_d == S_WR);
`endif
            if (bus.d_gnt) begin
                is_data_q <= 1'b1;
                if (!d_mis_c)
                    mem_addr_q <= {bus.d_addr[ADDR_W-1:3], 3'b000};
                if (state_d == S_WR)
                    mem_wdata_q <= bus.d_wdata;
            end else if (bus.if_gnt) begin
                is_data_q  <= 1'b0;
                hi_q       <= bus.if_addr[2];
                mem_addr_q <= {bus.if_addr[ADDR_W-1:3], 3'b000};
            end
            case (state_q)
                S_RWAIT: begin
                    if (is_data_q) begin
                        d_rdata_q  <= bus.mem_rdata;
                        d_rvalid_q <= 1'b1;
                    end else begin
                        if_rdata_q  <= hi_q ? bus.mem_rdata[2*INSN_W-1:INSN_W]
                                            : bus.mem_rdata[INSN_W-1:0];
                        if_rvalid_q <= 1'b1;
                    end
                end
                S_WR:       d_rvalid_q <= 1'b1;
                S_ERR: begin
                    d_rvalid_q <= 1'b1;
                    d_err_q    <= 1'b1;
                end
`ifdef MEM_ARB_RMW_EN
                S_RMW_WAIT: mem_wdata_q <= merged_c;
                S_RMW_WR:   d_rvalid_q  <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory behind the pins.
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: read data one cycle after the address, plus a back-door preload port.
    logic [63:0] mem [0:255];
    logic        tb_wr;
    logic [7:0]  tb_idx;
    logic [63:0] tb_val;

    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr[10:3]];
        if (bus.mem_wr)
            mem[bus.mem_addr[10:3]] <= bus.mem_wdata;
        else if (tb_wr)
            mem[tb_idx] <= tb_val;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [63:0] val);
        @(negedge clk);
        tb_wr  = 1'b1;
        tb_idx = addr[10:3];
        tb_val = val;
        @(negedge clk);
        tb_wr  = 1'b0;
    endtask

    // Offer a data request in IDLE, expect an immediate grant, drop it after the grant edge.
    task automatic issue_d(input string tag, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [63:0] wdata);
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_size  = size;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        #1;
        chk_eq({tag, "_dgnt"}, 64'(bus.d_gnt), 64'd1);
        @(posedge clk);
        #1 bus.d_req = 1'b0;
    endtask

    task automatic issue_if(input string tag, input logic [31:0] addr);
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        #1;
        chk_eq({tag, "_ifgnt"}, 64'(bus.if_gnt), 64'd1);
        @(posedge clk);
        #1 bus.if_req = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        tb_wr = 1'b0; tb_idx = '0; tb_val = '0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'd0;
        bus.d_addr = '0; bus.d_wdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("rst_mem_addr",  64'(bus.mem_addr), 64'd0);
        chk_eq("rst_mem_wr",    64'(bus.mem_wr), 64'd0);
        chk_eq("rst_mem_wdata", bus.mem_wdata, 64'd0);
        chk_eq("rst_rvalids",   64'({bus.if_rvalid, bus.d_rvalid, bus.d_err}), 64'd0);
        chk_eq("rst_rdata",     bus.d_rdata | 64'(bus.if_rdata), 64'd0);
        reset = 1'b0;

        preload(32'h100, 64'hAAAA_BBBB_CCCC_DDDD);
        preload(32'h200, 64'h0);

        // Fetch from the upper half of dword 0x100.
        issue_if("fetch", 32'h104);
        @(negedge clk);
        chk_eq("fetch_t1_addr", 64'(bus.mem_addr), 64'h100);
        chk_eq("fetch_t1_wr",   64'(bus.mem_wr), 64'd0);
        @(negedge clk);
        chk_eq("fetch_t2_rv",   64'(bus.if_rvalid), 64'd0);
        @(negedge clk);
        chk_eq("fetch_t3_rv",   64'(bus.if_rvalid), 64'd1);
        chk_eq("fetch_t3_data", 64'(bus.if_rdata), 64'hAAAA_BBBB);
        @(negedge clk);
        chk_eq("fetch_t4_rv",   64'(bus.if_rvalid), 64'd0);

        // Both requesters at once: data first, then the waiting fetch beats a re-raised data.
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd3; bus.d_addr = 32'h100;
        #1;
        chk_eq("arb_dgnt",  64'(bus.d_gnt), 64'd1);
        chk_eq("arb_iflose", 64'(bus.if_gnt), 64'd0);
        @(posedge clk);
        #1 bus.d_req = 1'b0;
        @(negedge clk);
        chk_eq("arb_busy_ifgnt", 64'(bus.if_gnt), 64'd0);
        @(negedge clk);
        bus.d_req = 1'b1;
        #1;
        chk_eq("arb_busy_dgnt", 64'(bus.d_gnt), 64'd0);
        @(negedge clk);
        chk_eq("arb_ld_rv",    64'(bus.d_rvalid), 64'd1);
        chk_eq("arb_ld_data",  bus.d_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
        chk_eq("arb_fair_if",  64'(bus.if_gnt), 64'd1);
        chk_eq("arb_fair_d",   64'(bus.d_gnt), 64'd0);
        @(posedge clk);
        #1 bus.if_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("arb_if_rv",    64'(bus.if_rvalid), 64'd1);
        chk_eq("arb_if_data",  64'(bus.if_rdata), 64'hAAAA_BBBB);
        chk_eq("arb_d_next",   64'(bus.d_gnt), 64'd1);
        @(posedge clk);
        #1 bus.d_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("arb_d2_rv",    64'(bus.d_rvalid), 64'd1);

        // Byte store to 0x203 over a zero dword.
        issue_d("sb", 1'b1, 2'd0, 32'h203, 64'h5A);
        @(negedge clk);
        chk_eq("sb_t1_addr", 64'(bus.mem_addr), 64'h200);
`ifdef MEM_ARB_RMW_EN
        chk_eq("sb_t1_wr",   64'(bus.mem_wr), 64'd0);
        @(negedge clk);
        chk_eq("sb_t2_wr",   64'(bus.mem_wr), 64'd0);
        @(negedge clk);
        chk_eq("sb_t3_wr",   64'(bus.mem_wr), 64'd1);
        chk_eq("sb_t3_wdata", bus.mem_wdata, 64'h0000_0000_5A00_0000);
        chk_eq("sb_t3_rv",   64'(bus.d_rvalid), 64'd0);
`else
        chk_eq("sb_t1_wr",   64'(bus.mem_wr), 64'd1);
        chk_eq("sb_t1_wdata", bus.mem_wdata, 64'h5A);
`endif
        @(negedge clk);
        chk_eq("sb_ack_rv",  64'(bus.d_rvalid), 64'd1);
        chk_eq("sb_ack_err", 64'(bus.d_err), 64'd0);
        chk_eq("sb_ack_wr",  64'(bus.mem_wr), 64'd0);

        // Half store to 0x206, then read the whole dword back.
        issue_d("sh", 1'b1, 2'd1, 32'h206, 64'h1234);
`ifdef MEM_ARB_RMW_EN
        repeat (4) @(negedge clk);
`else
        repeat (2) @(negedge clk);
`endif
        chk_eq("sh_ack_rv", 64'(bus.d_rvalid), 64'd1);
        issue_d("ld200", 1'b0, 2'd3, 32'h200, 64'h0);
        repeat (3) @(negedge clk);
        chk_eq("ld200_rv", 64'(bus.d_rvalid), 64'd1);
`ifdef MEM_ARB_RMW_EN
        chk_eq("ld200_data", bus.d_rdata, 64'h1234_0000_5A00_0000);
`else
        chk_eq("ld200_data", bus.d_rdata, 64'h0000_0000_0000_1234);
`endif

        // Misaligned word load: no memory activity, error response at T+2.
        issue_d("mis", 1'b0, 2'd2, 32'h302, 64'h0);
        @(negedge clk);
        chk_eq("mis_t1_wr",   64'(bus.mem_wr), 64'd0);
        chk_eq("mis_t1_addr", 64'(bus.mem_addr), 64'h200);
        chk_eq("mis_t1_rv",   64'(bus.d_rvalid), 64'd0);
        @(negedge clk);
        chk_eq("mis_t2_err",  64'(bus.d_err), 64'd1);
        chk_eq("mis_t2_rv",   64'(bus.d_rvalid), 64'd1);
        @(negedge clk);
        chk_eq("mis_t3_pulse", 64'({bus.d_err, bus.d_rvalid}), 64'd0);

        // Dword store then load at 0x400.
        issue_d("sd", 1'b1, 2'd3, 32'h400, 64'h1122_3344_5566_7788);
        @(negedge clk);
        chk_eq("sd_t1_wr",    64'(bus.mem_wr), 64'd1);
        chk_eq("sd_t1_wdata", bus.mem_wdata, 64'h1122_3344_5566_7788);
        @(negedge clk);
        chk_eq("sd_ack_rv",   64'(bus.d_rvalid), 64'd1);
        issue_d("ld400", 1'b0, 2'd3, 32'h400, 64'h0);
        repeat (2) @(negedge clk);
        chk_eq("ld400_t2_rv", 64'(bus.d_rvalid), 64'd0);
        @(negedge clk);
        chk_eq("ld400_rv",    64'(bus.d_rvalid), 64'd1);
        chk_eq("ld400_data",  bus.d_rdata, 64'h1122_3344_5566_7788);

        // Reset asserted while a load sits in RWAIT.
        issue_d("rst_ld", 1'b0, 2'd3, 32'h100, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_eq("rst_mid_addr",  64'(bus.mem_addr), 64'd0);
        chk_eq("rst_mid_rdata", bus.d_rdata, 64'd0);
        chk_eq("rst_mid_wdata", bus.mem_wdata, 64'd0);
        chk_eq("rst_mid_irdat", 64'(bus.if_rdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_eq("rst_mid_norv", 64'({bus.d_rvalid, bus.if_rvalid, bus.mem_wr}), 64'd0);
        issue_if("post_rst", 32'h100);
        repeat (3) @(negedge clk);
        chk_eq("post_rst_rv",   64'(bus.if_rvalid), 64'd1);
        chk_eq("post_rst_data", 64'(bus.if_rdata), 64'hCCCC_DDDD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and access sequencer for the single-port 64-bit memory shared by the multicycle core's instruction fetch and its load/store path. It grants one requester at a time, drives the memory address, write-enable and write-data pins, and returns read data or a write acknowledgement. It detects misaligned data accesses and, when configured, performs sub-word stores internally as read-modify-write.

## Interface
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 64: memory word width. The design supports only 64.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request. Held high until `if_gnt`.
- `if_addr` in ADDR_W: fetch byte address, 4-aligned.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: one-cycle pulse when `if_rdata` is valid.
- `if_rdata` out 32: instruction. Equals `mem_rdata[63:32]` if `if_addr[2]` is set, else `mem_rdata[31:0]`.
- `d_req` in 1: data request. Held high until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in 64: store data, right-aligned.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: one-cycle pulse marking load data valid, store complete, or error.
- `d_rdata` out 64: full aligned memory dword. Lane extraction and extension are done downstream.
- `d_err` out 1: misaligned access. Valid only together with `d_rvalid`.
- `mem_addr` out ADDR_W: memory address, with `[2:0]` forced to 0.
- `mem_wr` out 1: memory write enable.
- `mem_wdata` out 64: memory write data.
- `mem_rdata` in 64: memory read data. Valid the cycle after a read address is presented.

## Operation
- FSM states: IDLE, RD, RWAIT, WR, ERR, RMW_RD, RMW_WAIT, RMW_WR.
- Grants are combinational and issued only in IDLE. Request fields are sampled into holding registers on the granting edge and are ignored at all other times.
- Arbitration: data wins over fetch. Exception: when the previous grant went to data and `if_req` is high, fetch wins. A 1-bit `last_was_data` register implements this.
- Misalignment rule:
  - half with `addr[0]` set;
  - word with `addr[1:0]` ≠ 0;
  - dword with `addr[2:0]` ≠ 0;
  - byte is never misaligned.
- Misaligned data request: IDLE→ERR. No memory access takes place.
- Load or fetch: IDLE→RD. In RD, `mem_addr` is driven and `mem_wr`=0. RD→RWAIT. In RWAIT, `mem_rdata` is captured into the rdata register. RWAIT→IDLE, with the rvalid pulse asserted in the IDLE cycle.
- Store, full dword (or any size without the macro): IDLE→WR. In WR, `mem_wr`=1 and `mem_wdata`=`d_wdata`. WR→IDLE, with the `d_rvalid` pulse in IDLE.
- Sub-word store (macro on): IDLE→RMW_RD→RMW_WAIT→RMW_WR→IDLE.
  - RMW_WAIT merges the size-masked `d_wdata`, shifted left by `addr[2:0]`×8, into the captured `mem_rdata`.
  - RMW_WR writes the merged word.
- ERR→IDLE: `d_err`=1 and `d_rvalid`=1 in the following IDLE cycle.
- `if_rvalid`, `d_rvalid` and `d_err` are registered pulses, each exactly one cycle long. `if_rdata` and `d_rdata` hold their value until the next read completes.
- IDLE may grant a new request in the same cycle that an rvalid pulse is driven.
- Outside RD, WR and the RMW states, `mem_addr` holds its last value and `mem_wr`=0.

## Timing
- Cycle numbering: grant edge is T.
  - Load/fetch: `if_rvalid`/`d_rvalid` at T+3.
  - Store: ack at T+2.
  - RMW store: ack at T+4.
  - Error: `d_err`+`d_rvalid` at T+2.
- Reset (asynchronous, any state): state=IDLE, `last_was_data`=0. All outputs go to 0, including `mem_addr`, `mem_wdata`, `if_rdata` and `d_rdata`.
- Reset mid-operation: an in-flight access is dropped with no rvalid. `mem_wr` falls immediately.
- Simultaneous `if_req` and `d_req` in IDLE: exactly one grant follows the arbitration rule. The loser keeps its request and is granted at the next IDLE.
- Requests arriving outside IDLE are not granted. The requester keeps waiting.
- Address wrap-around is not special-cased: `mem_addr` = `{addr[ADDR_W-1:3], 3'b0}`.

## Configuration
- `MEM_ARB_RMW_EN`
  - Defined: size-0/1/2 stores take the RMW path and only the addressed bytes change.
  - Undefined: the RMW states are not compiled. Every store writes `d_wdata` as a full dword via WR, and the requester is responsible for any merging. Misalignment checking is active in both builds.

## Test plan
- Fetch `if_addr`=0x104, memory dword at 0x100 = 0xAAAA_BBBB_CCCC_DDDD → `if_gnt` at T, `if_rvalid` at T+3, `if_rdata`=0xAAAA_BBBB.
- `d_req` and `if_req` both high in IDLE with `last_was_data`=0 → `d_gnt` wins. The next IDLE grants the still-pending fetch even if `d_req` is reasserted.
- Byte store, `d_addr`=0x203, `d_wdata`=0x5A, dword at 0x200 = 0 (macro on) → `mem_wr` at T+3 with `mem_wdata`=0x0000_0000_5A00_0000, ack at T+4. With the macro off → `mem_wdata`=0x5A at T+1, ack at T+2.
- Word load at `d_addr`=0x302 → no `mem_wr`, no RD cycle; `d_err`=1 and `d_rvalid`=1 at T+2.
- Dword store 0x1122_3344_5566_7788 to 0x400, then dword load from 0x400 → `d_rdata`=0x1122_3344_5566_7788 at the load's T+3.
- Assert `reset` during RWAIT → outputs are 0 immediately, no `d_rvalid`, and the next request is granted from IDLE.
